// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word and fetch stage FSM encoding.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    // Byte distance between sequential instruction words.
    localparam word_t PC_INC = 32'd4;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

endpackage : cpu_types_pkg

// File: rtl/fetch_stage_if.sv
// IF stage bus: icache request/response, hazard/redirect controls and the IF/ID write side.
interface fetch_stage_if;
    import cpu_types_pkg::*;

    logic  ihit;
    word_t imemload;
    logic  imemREN;
    word_t imemaddr;

    logic  stall_in;
    logic  redirect_en;
    word_t redirect_addr;
    logic  halt_in;

    word_t ifid_instruction;
    word_t ifid_pc;
    word_t ifid_pcn;
    logic  ifid_wen;
    logic  ifid_flush;

    // Fetch stage side.
    modport master (
        input  ihit, imemload, stall_in, redirect_en, redirect_addr, halt_in,
        output imemREN, imemaddr,
        output ifid_instruction, ifid_pc, ifid_pcn, ifid_wen, ifid_flush
    );

    // Icache / hazard unit / IF-ID register side.
    modport slave (
        output ihit, imemload, stall_in, redirect_en, redirect_addr, halt_in,
        input  imemREN, imemaddr,
        input  ifid_instruction, ifid_pc, ifid_pcn, ifid_wen, ifid_flush
    );

endinterface : fetch_stage_if

// File: rtl/fetch_skid_buf.sv
// One-entry {instruction, pc} holding register used while IF/ID is stalled.
module fetch_skid_buf
    import cpu_types_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  capture_i,
    input  logic  consume_i,
    input  logic  clear_i,
    input  word_t instr_i,
    input  word_t pc_i,
    output logic  valid_o,
    output word_t instr_o,
    output word_t pc_o
);

    logic  valid_q, valid_d;
    word_t instr_q, instr_d;
    word_t pc_q,    pc_d;

    // Next entry: clear wins over capture, capture over consume.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (capture_i) begin
            valid_d = 1'b1;
            instr_d = instr_i;
            pc_d    = pc_i;
        end else if (consume_i) begin
            valid_d = 1'b0;
        end
    end

    // Entry register; data fields need no reset since valid gates them.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule : fetch_skid_buf

// File: rtl/fetch_stage.sv
// MIPS IF stage: owns the PC, drives the icache and feeds the IF/ID register.
module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter word_t PC_RESET = 32'h0000_0000
) (
    input  logic          CLK,
    input  logic          RST,
    fetch_stage_if.master fif
);

    fetch_state_t state_q, state_d;
    word_t        pc_q,    pc_d;
    word_t        tgt_q,   tgt_d;

    logic  buf_valid_c;
    word_t buf_instr_c;
    word_t buf_pc_c;
    logic  buf_capture_c;
    logic  buf_consume_c;
    logic  buf_clear_c;

    logic  imem_ren_c;
    logic  fetch_done_c;
    logic  miss_c;
    word_t pc_inc_c;
    word_t ifid_pc_c;

    fetch_skid_buf u_skid_buf (
        .clk_i     (CLK),
        .rst_i     (RST),
        .capture_i (buf_capture_c),
        .consume_i (buf_consume_c),
        .clear_i   (buf_clear_c),
        .instr_i   (fif.imemload),
        .pc_i      (pc_q),
        .valid_o   (buf_valid_c),
        .instr_o   (buf_instr_c),
        .pc_o      (buf_pc_c)
    );

    // Icache request is withheld while halted or while the skid buffer is full.
    assign imem_ren_c   = (state_q != HALTED) && !buf_valid_c;
    assign fetch_done_c = (state_q == RUN) && imem_ren_c && fif.ihit;
    assign miss_c       = imem_ren_c && !fif.ihit;
    assign pc_inc_c     = pc_q + PC_INC;

    assign fif.imemREN  = imem_ren_c;
    assign fif.imemaddr = pc_q;
    assign fif.ifid_pc  = ifid_pc_c;
    assign fif.ifid_pcn = ifid_pc_c + PC_INC;

    // Next-state and IF/ID outputs; priority is reset, redirect, halt, stall.
    always_comb begin
        state_d              = state_q;
        pc_d                 = pc_q;
        tgt_d                = tgt_q;
        buf_capture_c        = 1'b0;
        buf_consume_c        = 1'b0;
        buf_clear_c          = 1'b0;
        fif.ifid_wen         = 1'b0;
        fif.ifid_flush       = 1'b0;
        fif.ifid_instruction = fif.imemload;
        ifid_pc_c            = pc_q;

        if (RST) begin
            fif.ifid_wen   = 1'b1;
            fif.ifid_flush = 1'b1;
        end else if (fif.redirect_en) begin
            fif.ifid_wen   = 1'b1;
            fif.ifid_flush = 1'b1;
            buf_clear_c    = 1'b1;
            if (miss_c) begin
                // Outstanding miss must complete before the PC may move.
                tgt_d   = fif.redirect_addr;
                state_d = DRAIN;
            end else begin
                pc_d    = fif.redirect_addr;
                state_d = RUN;
            end
        end else if (state_q == HALTED) begin
            fif.ifid_wen   = 1'b1;
            fif.ifid_flush = 1'b1;
        end else if (fif.halt_in) begin
            fif.ifid_wen   = !fif.stall_in;
            fif.ifid_flush = 1'b1;
            buf_clear_c    = 1'b1;
            state_d        = HALTED;
        end else if (state_q == DRAIN) begin
            fif.ifid_wen   = 1'b1;
            fif.ifid_flush = 1'b1;
            if (fif.ihit) begin
                pc_d    = tgt_q;
                state_d = RUN;
            end
        end else if (fif.stall_in) begin
            if (fetch_done_c) begin
                buf_capture_c = 1'b1;
                pc_d          = pc_inc_c;
            end
        end else if (buf_valid_c) begin
            fif.ifid_wen         = 1'b1;
            fif.ifid_instruction = buf_instr_c;
            ifid_pc_c            = buf_pc_c;
            buf_consume_c        = 1'b1;
        end else if (fetch_done_c) begin
            fif.ifid_wen = 1'b1;
            pc_d         = pc_inc_c;
        end else begin
            fif.ifid_wen   = 1'b1;
            fif.ifid_flush = 1'b1;
        end
    end

    // State, PC and pending redirect target registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= RUN;
            pc_q    <= PC_RESET;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
        end
    end

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed walk-through plus randomized traffic.
module tb_fetch_stage;
    import cpu_types_pkg::*;

    typedef struct packed {
        word_t instr;
        word_t pc;
    } ent_t;

    logic clk = 1'b0;
    logic rst;

    fetch_stage_if fif ();

    fetch_stage #(.PC_RESET(32'h0000_0000)) dut (
        .CLK (clk),
        .RST (rst),
        .fif (fif)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model state.
    bit    m_halted;
    bit    m_drain;
    word_t m_pc;
    word_t m_tgt;
    ent_t  m_buf[$];

    word_t last_addr;
    logic  last_ren;
    word_t last_pcn;
    logic  last_flush;
    logic  last_wen;

    task automatic check(input string tag, input word_t got, input word_t exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Icache contents: a fixed scramble of the word address.
    function automatic word_t mem(input word_t a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic model_reset();
        m_halted = 1'b0;
        m_drain  = 1'b0;
        m_pc     = 32'h0;
        m_tgt    = 32'h0;
        m_buf.delete();
    endtask

    // One clock cycle: drive inputs, compare against the model, advance the model.
    task automatic step(input bit r, input bit hit, input bit stall,
                        input bit redir, input word_t raddr, input bit halt);
        bit    e_ren, e_wen, e_flush, issue, got;
        ent_t  e_ent;
        word_t e_addr;

        @(negedge clk);
        rst               = r;
        fif.ihit          = hit;
        fif.stall_in      = stall;
        fif.redirect_en   = redir;
        fif.redirect_addr = raddr;
        fif.halt_in       = halt;
        fif.imemload      = hit ? mem(m_pc) : $urandom();

        e_ren   = !m_halted && (m_buf.size() == 0);
        e_addr  = m_pc;
        e_wen   = 1'b1;
        e_flush = 1'b1;
        issue   = 1'b0;
        e_ent   = '0;

        if (r) begin
            model_reset();
        end else if (redir) begin
            m_buf.delete();
            m_halted = 1'b0;
            if (e_ren && !hit) begin
                m_drain = 1'b1;
                m_tgt   = raddr;
            end else begin
                m_drain = 1'b0;
                m_pc    = raddr;
            end
        end else if (m_halted) begin
            // stays halted, continuous bubbles
        end else if (halt) begin
            e_wen    = !stall;
            m_buf.delete();
            m_halted = 1'b1;
            m_drain  = 1'b0;
        end else if (m_drain) begin
            if (hit) begin
                m_drain = 1'b0;
                m_pc    = m_tgt;
            end
        end else begin
            got = hit && e_ren;
            if (stall) begin
                e_wen   = 1'b0;
                e_flush = 1'b0;
                if (got) begin
                    m_buf.push_back('{instr: mem(m_pc), pc: m_pc});
                    m_pc = m_pc + 32'd4;
                end
            end else if (m_buf.size() != 0) begin
                issue = 1'b1;
                e_ent = m_buf.pop_front();
            end else if (got) begin
                issue = 1'b1;
                e_ent = '{instr: mem(m_pc), pc: m_pc};
                m_pc  = m_pc + 32'd4;
            end
        end
        if (issue) e_flush = 1'b0;

        #1;
        last_addr  = fif.imemaddr;
        last_ren   = fif.imemREN;
        last_pcn   = fif.ifid_pcn;
        last_flush = fif.ifid_flush;
        last_wen   = fif.ifid_wen;
        check("wen", 32'(fif.ifid_wen), 32'(e_wen));
        check("flush", 32'(fif.ifid_flush), 32'(e_flush));
        if (!r) begin
            check("imemREN", 32'(fif.imemREN), 32'(e_ren));
            check("imemaddr", fif.imemaddr, e_addr);
        end
        if (issue) begin
            check("instr", fif.ifid_instruction, e_ent.instr);
            check("pc", fif.ifid_pc, e_ent.pc);
            check("pcn", fif.ifid_pcn, e_ent.pc + 32'd4);
        end
    endtask

    initial begin
        int    sel;
        word_t ra;
        rst               = 1'b1;
        fif.ihit          = 1'b0;
        fif.imemload      = '0;
        fif.stall_in      = 1'b0;
        fif.redirect_en   = 1'b0;
        fif.redirect_addr = '0;
        fif.halt_in       = 1'b0;
        model_reset();

        // Reset, then back-to-back hits from address 0.
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        check("tp_rst_flush", 32'(last_flush), 32'd1);
        step(0, 1, 0, 0, 0, 0);
        check("tp_addr0", last_addr, 32'h0);
        check("tp_pcn0", last_pcn, 32'h4);
        step(0, 1, 0, 0, 0, 0);
        check("tp_addr4", last_addr, 32'h4);
        // Miss at 8 for three cycles, then hit.
        repeat (3) step(0, 0, 0, 0, 0, 0);
        check("tp_miss_addr", last_addr, 32'h8);
        step(0, 1, 0, 0, 0, 0);
        check("tp_miss_pcn", last_pcn, 32'd12);
        step(0, 1, 0, 0, 0, 0);
        // Stall with hit at 16: buffered, then issued without re-fetch.
        step(0, 1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        check("tp_stall_ren", 32'(last_ren), 32'd0);
        step(0, 1, 0, 0, 0, 0);
        check("tp_skid_addr", last_addr, 32'd20);
        step(0, 1, 0, 0, 0, 0);
        // Redirect during miss at 24.
        step(0, 0, 0, 1, 32'h100, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        check("tp_drain_addr", last_addr, 32'h100);
        // Redirect while stalled with a full buffer.
        step(0, 1, 1, 0, 0, 0);
        step(0, 1, 1, 1, 32'h200, 0);
        step(0, 1, 0, 0, 0, 0);
        check("tp_redir_addr", last_addr, 32'h200);
        // Halt at 0x40, resume at 0x80.
        step(0, 1, 0, 1, 32'h40, 0);
        step(0, 1, 0, 0, 0, 1);
        repeat (3) step(0, 1, 0, 0, 0, 0);
        check("tp_halt_ren", 32'(last_ren), 32'd0);
        step(0, 1, 0, 1, 32'h80, 0);
        step(0, 1, 0, 0, 0, 0);
        check("tp_resume_addr", last_addr, 32'h80);
        // PC wrap at the top of the address space.
        step(0, 1, 0, 1, 32'hFFFF_FFFC, 0);
        step(0, 1, 0, 0, 0, 0);
        check("tp_wrap_pcn", last_pcn, 32'h0);
        step(0, 1, 0, 0, 0, 0);
        check("tp_wrap_addr", last_addr, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            sel = int'($urandom_range(0, 3));
            case (sel)
                0:       ra = 32'hFFFF_FFFC;
                1:       ra = 32'hFFFF_FFF8;
                2:       ra = 32'h0;
                default: ra = $urandom() & 32'hFFFF_FFFC;
            endcase
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 9) < 7,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 19) == 0,
                 ra,
                 $urandom_range(0, 49) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_fetch_stage

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the 5-stage MIPS pipeline; owns the PC and drives the icache request.
- Produces the input side of the IF/ID pipe register: instruction, PC, PC+4, WEN and flush.
- Holds one fetched instruction in a skid buffer while stalled, so a stall never causes a re-fetch.
- Handles branch/jump redirects (including one arriving during an outstanding miss) and halt.

Parameters:
- PC_RESET, 32'h0000_0000, PC value after reset.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- ihit  in  1  icache returns instruction this cycle.
- imemload  in  32  icache instruction data, valid when ihit.
- imemREN  out  1  icache read request.
- imemaddr  out  32  icache address, equals the PC register.
- stall_in  in  1  hazard unit holds IF/ID.
- redirect_en  in  1  single-cycle redirect pulse (branch taken, jump, jr).
- redirect_addr  in  32  redirect target, word-aligned.
- halt_in  in  1  ID has decoded a halt.
- ifid_instruction  out  32  to IF/ID instruction_in.
- ifid_pc  out  32  address of ifid_instruction, to IF/ID next_address_in.
- ifid_pcn  out  32  ifid_pc+4, to IF/ID pcn_in.
- ifid_wen  out  1  to IF/ID WEN.
- ifid_flush  out  1  to IF/ID flush (insert NOP).

Behaviour:
- States:
  - RUN: normal fetch.
  - DRAIN: redirect arrived during a miss; wait for ihit, discard the data, then load the target.
  - HALTED: no fetch.
- Reset (synchronous, overrides everything):
  - state=RUN, pc=PC_RESET, buf_valid=0, pending target=0.
  - ifid_wen=1 and ifid_flush=1 during the reset cycle.
- imemaddr = pc at all times. pc holds stable while imemREN=1 and ihit=0.
- imemREN = 1 iff state is RUN or DRAIN and buf_valid=0.
- Fetch completes in a cycle with imemREN=1 and ihit=1 in state RUN.
- ifid_* outputs are combinational; an instruction appears at the IF/ID outputs one cycle after its completing ihit.
- Priority, highest first: RST, redirect_en, halt_in, stall_in.
- redirect_en=1:
  - Outputs: ifid_wen=1, ifid_flush=1 (squash, even if stall_in=1); buf_valid cleared.
  - If imemREN=1 and ihit=0 this cycle (miss outstanding): latch redirect_addr, go to DRAIN.
  - Otherwise: pc<=redirect_addr, state<=RUN. This also exits HALTED.
- DRAIN:
  - ifid_wen=1, ifid_flush=1 every cycle.
  - On ihit: pc<=latched target, state<=RUN.
  - A new redirect_en while in DRAIN overwrites the latched target.
- halt_in=1 (no redirect): state<=HALTED; ifid_flush=1, ifid_wen=!stall_in; buf_valid cleared; pc unchanged.
- HALTED: imemREN=0, ifid_wen=1, ifid_flush=1. Only redirect_en or RST exits.
- Normal issue (RUN, no redirect, no halt):
  - stall_in=1: ifid_wen=0, ifid_flush=0. If the fetch completes and buf_valid=0, capture {imemload, pc} into the buffer, buf_valid<=1, pc<=pc+4.
  - stall_in=0 and buf_valid=1: issue the buffer (flush=0, wen=1), buf_valid<=0. imemREN is 0 this cycle.
  - stall_in=0, buf_valid=0, fetch completes: issue imemload with ifid_pc=pc, pcn=pc+4, flush=0, wen=1; pc<=pc+4.
  - stall_in=0, no instruction available (miss): wen=1, flush=1 (bubble).
- Arithmetic: pc+4 is 32-bit unsigned and wraps mod 2^32 (32'hFFFF_FFFC -> 0). ifid_pcn is likewise mod 2^32.
- The buffer never holds more than one entry. imemREN=0 while it is full, so no overflow is possible.

Decomposition:
- cpu_types_pkg gains:
  - fetch_state_t enum {RUN, DRAIN, HALTED}.
  - localparam PC_INC = 32'd4.
- Uses word_t from the package.
- One sub-module: fetch_skid_buf (one-entry {instruction, pc} holding register, with capture/consume/clear).
- Everything else in fetch_stage.

Test Plan:
- Reset with ihit tied 1 -> imemaddr=0, 4, 8 on consecutive cycles; IF/ID gets instruction@0 with pcn=4, flush=0.
- Miss: ihit=0 for 3 cycles at pc=8 -> imemaddr stays 8, three bubbles (wen=1, flush=1); ihit=1 issues instruction@8 with pcn=12.
- Stall: stall_in=1 for 2 cycles while ihit=1 at pc=16 -> instruction@16 buffered, imemREN=0 in the second cycle, wen=0 both cycles; on release, instruction@16 issues and imemaddr=20 with no re-fetch.
- Redirect during miss: pc=24, ihit=0, redirect to 0x100 -> DRAIN; ihit after 2 cycles is discarded; next imemaddr=0x100; no instruction from 24 reaches IF/ID.
- Redirect with stall_in=1 and buf_valid=1 -> wen=1, flush=1, buffer cleared, next imemaddr=redirect_addr.
- halt_in at pc=0x40 -> imemREN=0 and continuous flush; redirect to 0x80 resumes fetch at 0x80. Separately, pc=32'hFFFF_FFFC with ihit -> next pc=0, pcn=0.
